// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with write-through bypass and a per-register
// pending scoreboard for RAW hazard detection at issue.
`default_nettype none

module regfile_mp #(
  parameter int DSIZE   = 32,
  parameter int NREG    = 32,
  parameter int NRD     = 2,
  parameter int NWR     = 1,
  parameter int ZERO_R0 = 1,
  localparam int ASIZE  = $clog2(NREG)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NRD*ASIZE-1:0]   raddr,
  output logic [NRD*DSIZE-1:0]   rdata,
  output logic [NRD-1:0]         rbusy,
  input  logic [NWR-1:0]         wen,
  input  logic [NWR*ASIZE-1:0]   waddr,
  input  logic [NWR*DSIZE-1:0]   wdata,
  input  logic                   alloc_en,
  input  logic [ASIZE-1:0]       alloc_addr,
  output logic [ASIZE:0]         pending_cnt,
  output logic                   idle
);

  // Bit r clear means register r can never be written or allocated.
  localparam logic [NREG-1:0] WR_MASK = {{(NREG-1){1'b1}}, (ZERO_R0 == 0)};

  logic [DSIZE-1:0] regs    [NREG];
  logic [DSIZE-1:0] wr_data [NREG];
  logic [NREG-1:0]  wr_hit;
  logic [NREG-1:0]  wr_en;
  logic [NREG-1:0]  alloc_hit;
  logic [NREG-1:0]  pending;
  logic [NREG-1:0]  pending_nxt;
  logic [ASIZE:0]   cnt_nxt;

  function automatic logic [ASIZE:0] popcount(input logic [NREG-1:0] v);
    logic [ASIZE:0] c;
    c = '0;
    for (int i = 0; i < NREG; i++) begin
      c = c + {{ASIZE{1'b0}}, v[i]};
    end
    return c;
  endfunction

  // Per-register write decode; ascending scan lets the highest port index win.
  always_comb begin
    wr_hit = '0;
    for (int r = 0; r < NREG; r++) begin
      wr_data[r] = '0;
      for (int j = 0; j < NWR; j++) begin
        if (wen[j] && (waddr[j*ASIZE +: ASIZE] == ASIZE'(r))) begin
          wr_hit[r]  = 1'b1;
          wr_data[r] = wdata[j*DSIZE +: DSIZE];
        end
      end
    end
  end

  assign wr_en = wr_hit & WR_MASK;

  always_comb begin
    alloc_hit = '0;
    if (alloc_en) begin
      alloc_hit[alloc_addr] = 1'b1;
    end
    alloc_hit = alloc_hit & WR_MASK;
  end

  // A new producer supersedes a same-cycle writeback of the old one.
  assign pending_nxt = alloc_hit | (pending & ~wr_en);
  assign cnt_nxt     = popcount(pending_nxt);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        regs[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (wr_en[r]) begin
          regs[r] <= wr_data[r];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending     <= '0;
      pending_cnt <= '0;
      idle        <= 1'b1;
    end else begin
      pending     <= pending_nxt;
      pending_cnt <= cnt_nxt;
      idle        <= (cnt_nxt == '0);
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ASIZE-1:0] ra;
    logic             zero_rd;
    assign ra      = raddr[k*ASIZE +: ASIZE];
    assign zero_rd = (ZERO_R0 != 0) && (ra == '0);
    assign rdata[k*DSIZE +: DSIZE] = zero_rd                 ? '0 :
                                     (!rst && wr_hit[ra])    ? wr_data[ra] :
                                                               regs[ra];
    assign rbusy[k] = !rst && pending[ra] && !wr_hit[ra];
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed scenarios plus randomized traffic against an array model.
`default_nettype none

module tb_regfile_mp;
  localparam int DSIZE = 32;
  localparam int NREG  = 32;
  localparam int ASIZE = 5;
  localparam int NRD   = 2;
  localparam int NWR   = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NRD*ASIZE-1:0] raddr;
  logic [NRD*DSIZE-1:0] rdata;
  logic [NRD-1:0]       rbusy;
  logic [NWR-1:0]       wen;
  logic [NWR*ASIZE-1:0] waddr;
  logic [NWR*DSIZE-1:0] wdata;
  logic                 alloc_en;
  logic [ASIZE-1:0]     alloc_addr;
  logic [ASIZE:0]       pending_cnt;
  logic                 idle;

  int total = 0;
  int bad   = 0;

  logic [DSIZE-1:0] m_regs [NREG];
  bit               m_pend [NREG];
  int               m_cnt;

  regfile_mp #(.DSIZE(DSIZE), .NREG(NREG), .NRD(NRD), .NWR(NWR), .ZERO_R0(1)) dut (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .wen(wen), .waddr(waddr), .wdata(wdata), .alloc_en(alloc_en),
    .alloc_addr(alloc_addr), .pending_cnt(pending_cnt), .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic set_rd(input int k, input int a);
    raddr[k*ASIZE +: ASIZE] = ASIZE'(a);
  endtask

  task automatic set_wr(input int j, input bit en, input int a, input logic [DSIZE-1:0] d);
    wen[j] = en;
    waddr[j*ASIZE +: ASIZE] = ASIZE'(a);
    wdata[j*DSIZE +: DSIZE] = d;
  endtask

  task automatic clear_in();
    wen = '0;
    alloc_en = 1'b0;
  endtask

  function automatic logic [DSIZE-1:0] get_rd(input int k);
    return rdata[k*DSIZE +: DSIZE];
  endfunction

  function automatic bit write_hits(input int a);
    for (int j = 0; j < NWR; j++)
      if (wen[j] && int'(waddr[j*ASIZE +: ASIZE]) == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [DSIZE-1:0] exp_rd(input int a);
    logic [DSIZE-1:0] v;
    if (a == 0) return '0;
    v = m_regs[a];
    if (!rst)
      for (int j = 0; j < NWR; j++)
        if (wen[j] && int'(waddr[j*ASIZE +: ASIZE]) == a) v = wdata[j*DSIZE +: DSIZE];
    return v;
  endfunction

  function automatic bit exp_busy(input int a);
    if (rst) return 1'b0;
    return m_pend[a] && !write_hits(a);
  endfunction

  // Advance one clock and apply the edge's effect to the model.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        m_regs[r] = '0;
        m_pend[r] = 1'b0;
      end
    end else begin
      for (int j = 0; j < NWR; j++) begin
        int a;
        a = int'(waddr[j*ASIZE +: ASIZE]);
        if (wen[j] && a != 0) begin
          m_regs[a] = wdata[j*DSIZE +: DSIZE];
          m_pend[a] = 1'b0;
        end
      end
      if (alloc_en && alloc_addr != 0) m_pend[alloc_addr] = 1'b1;
    end
    m_cnt = 0;
    for (int r = 0; r < NREG; r++) m_cnt += int'(m_pend[r]);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; alloc_en = 1'b0; alloc_addr = '0;
    set_wr(0, 1'b1, 3, 32'hFFFF); set_wr(1, 1'b0, 0, '0);
    set_rd(0, 3); set_rd(1, 5);
    tick(); tick();
    total++; if (get_rd(0) !== 32'h0) begin bad++; $display("FAIL reset_rdata0 got=%h exp=0", get_rd(0)); end
    total++; if (get_rd(1) !== 32'h0) begin bad++; $display("FAIL reset_rdata1 got=%h exp=0", get_rd(1)); end
    total++; if (rbusy !== 2'b00) begin bad++; $display("FAIL reset_rbusy got=%b exp=00", rbusy); end
    total++; if (pending_cnt !== 6'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", pending_cnt); end
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL reset_idle got=%b exp=1", idle); end
    rst = 1'b0; clear_in();
    tick();
    total++; if (get_rd(0) !== 32'h0) begin bad++; $display("FAIL reset_r3_after got=%h exp=0", get_rd(0)); end
  endtask

  task automatic test_write_bypass();
    set_wr(0, 1'b1, 5, 32'h1234); set_rd(0, 5); #1;
    total++; if (get_rd(0) !== 32'h1234) begin bad++; $display("FAIL bypass_r5 got=%h exp=1234", get_rd(0)); end
    tick(); clear_in(); #1;
    total++; if (get_rd(0) !== 32'h1234) begin bad++; $display("FAIL stored_r5 got=%h exp=1234", get_rd(0)); end
    set_wr(0, 1'b1, 0, 32'hAAAA); set_rd(0, 0); #1;
    total++; if (get_rd(0) !== 32'h0) begin bad++; $display("FAIL bypass_r0 got=%h exp=0", get_rd(0)); end
    tick(); clear_in(); #1;
    total++; if (get_rd(0) !== 32'h0) begin bad++; $display("FAIL stored_r0 got=%h exp=0", get_rd(0)); end
  endtask

  task automatic test_dual_write();
    set_wr(0, 1'b1, 7, 32'h1); set_wr(1, 1'b1, 7, 32'h2); set_rd(0, 7); #1;
    total++; if (get_rd(0) !== 32'h2) begin bad++; $display("FAIL dual_bypass got=%h exp=2", get_rd(0)); end
    tick(); clear_in(); #1;
    total++; if (get_rd(0) !== 32'h2) begin bad++; $display("FAIL dual_stored got=%h exp=2", get_rd(0)); end
  endtask

  task automatic test_scoreboard();
    alloc_en = 1'b1; alloc_addr = 5'd9; set_rd(1, 9); #1;
    total++; if (rbusy[1] !== 1'b0) begin bad++; $display("FAIL sb_alloc_same got=%b exp=0", rbusy[1]); end
    tick(); alloc_en = 1'b0; #1;
    total++; if (rbusy[1] !== 1'b1) begin bad++; $display("FAIL sb_busy got=%b exp=1", rbusy[1]); end
    total++; if (pending_cnt !== 6'd1) begin bad++; $display("FAIL sb_cnt got=%0d exp=1", pending_cnt); end
    total++; if (idle !== 1'b0) begin bad++; $display("FAIL sb_idle got=%b exp=0", idle); end
    tick();
    set_wr(0, 1'b1, 9, 32'h55); #1;
    total++; if (rbusy[1] !== 1'b0) begin bad++; $display("FAIL sb_wb_busy got=%b exp=0", rbusy[1]); end
    total++; if (get_rd(1) !== 32'h55) begin bad++; $display("FAIL sb_wb_data got=%h exp=55", get_rd(1)); end
    tick(); clear_in(); #1;
    total++; if (pending_cnt !== 6'd0) begin bad++; $display("FAIL sb_cnt_clr got=%0d exp=0", pending_cnt); end
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL sb_idle_clr got=%b exp=1", idle); end
    total++; if (rbusy[1] !== 1'b0) begin bad++; $display("FAIL sb_busy_clr got=%b exp=0", rbusy[1]); end
  endtask

  task automatic test_collision();
    alloc_en = 1'b1; alloc_addr = 5'd4; tick(); clear_in();
    alloc_en = 1'b1; alloc_addr = 5'd4; set_wr(0, 1'b1, 4, 32'h77); set_rd(0, 4); #1;
    total++; if (rbusy[0] !== 1'b0) begin bad++; $display("FAIL col_busy_same got=%b exp=0", rbusy[0]); end
    total++; if (get_rd(0) !== 32'h77) begin bad++; $display("FAIL col_bypass got=%h exp=77", get_rd(0)); end
    tick(); clear_in(); #1;
    total++; if (rbusy[0] !== 1'b1) begin bad++; $display("FAIL col_busy got=%b exp=1", rbusy[0]); end
    total++; if (pending_cnt !== 6'd1) begin bad++; $display("FAIL col_cnt got=%0d exp=1", pending_cnt); end
    total++; if (get_rd(0) !== 32'h77) begin bad++; $display("FAIL col_data got=%h exp=77", get_rd(0)); end
    set_wr(0, 1'b1, 4, 32'h78); tick(); clear_in();
  endtask

  task automatic test_mid_reset();
    for (int r = 1; r <= 3; r++) begin
      alloc_en = 1'b1; alloc_addr = ASIZE'(r); tick();
    end
    clear_in(); #1;
    total++; if (pending_cnt !== 6'd3) begin bad++; $display("FAIL mr_cnt3 got=%0d exp=3", pending_cnt); end
    rst = 1'b1; set_rd(0, 1); set_rd(1, 2); #1;
    total++; if (rbusy !== 2'b00) begin bad++; $display("FAIL mr_busy_in_rst got=%b exp=00", rbusy); end
    tick(); rst = 1'b0; #1;
    total++; if (pending_cnt !== 6'd0) begin bad++; $display("FAIL mr_cnt got=%0d exp=0", pending_cnt); end
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL mr_idle got=%b exp=1", idle); end
    for (int r = 0; r < NREG; r += 2) begin
      set_rd(0, r); set_rd(1, r + 1); #1;
      total++;
      if (rbusy !== 2'b00 || get_rd(0) !== '0 || get_rd(1) !== '0) begin
        bad++; $display("FAIL mr_reg%0d busy=%b d0=%h d1=%h exp busy=00 data=0", r, rbusy, get_rd(0), get_rd(1));
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(39) == 0);
      for (int j = 0; j < NWR; j++)
        set_wr(j, 1'($urandom_range(1)), int'($urandom_range(7)), $urandom);
      alloc_en   = ($urandom_range(2) == 0);
      alloc_addr = ASIZE'($urandom_range(7));
      for (int k = 0; k < NRD; k++) set_rd(k, int'($urandom_range(7)));
      #1;
      for (int k = 0; k < NRD; k++) begin
        int a;
        a = int'(raddr[k*ASIZE +: ASIZE]);
        total++;
        if (get_rd(k) !== exp_rd(a)) begin bad++; $display("FAIL rnd_rdata%0d n=%0d a=%0d got=%h exp=%h", k, n, a, get_rd(k), exp_rd(a)); end
        total++;
        if (rbusy[k] !== exp_busy(a)) begin bad++; $display("FAIL rnd_rbusy%0d n=%0d a=%0d got=%b exp=%b", k, n, a, rbusy[k], exp_busy(a)); end
      end
      tick();
      total++;
      if (int'(pending_cnt) != m_cnt || idle !== (m_cnt == 0)) begin
        bad++; $display("FAIL rnd_cnt n=%0d cnt=%0d idle=%b exp cnt=%0d idle=%b", n, pending_cnt, idle, m_cnt, (m_cnt == 0));
      end
    end
    rst = 1'b0; clear_in();
  endtask

  initial begin
    for (int r = 0; r < NREG; r++) begin
      m_regs[r] = '0;
      m_pend[r] = 1'b0;
    end
    m_cnt = 0;
    raddr = '0; wen = '0; waddr = '0; wdata = '0;
    test_reset();
    test_write_bypass();
    test_dual_write();
    test_scoreboard();
    test_collision();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
